// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out serializer with valid/ready input and framed serial output
// Optional even-parity bit after each word when PISO_SERIALIZER_PARITY_EN is defined.
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous reset, active-high
//   i_data   parallel word, sampled when i_valid & o_ready
//   i_valid  i_data valid
//   o_ready  a word can be accepted this cycle
//   o_sdata  registered serial bit (0 when o_svalid=0)
//   o_svalid o_sdata carries a bit
//   o_sfirst first bit of a word
//   o_busy   word in flight
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_sdata,
  output logic             o_svalid,
  output logic             o_sfirst,
  output logic             o_busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam logic [1:0] S_PAR   = 2'd2;
  logic r_par;
`endif
  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_word;
  logic             r_sdata, r_svalid, r_sfirst;
  logic             w_last, w_acc;
  // Word reordered so the bit to send first is always at the top of the shifter
  always_comb
    for (int i = 0; i < WIDTH; i++)
      w_word[i] = MSB_FIRST ? i_data[i] : i_data[WIDTH-1-i];
  assign w_last = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH-1));
`ifdef PISO_SERIALIZER_PARITY_EN
  assign o_ready = !i_rst && (r_state == S_IDLE || r_state == S_PAR);
`else
  assign o_ready = !i_rst && (r_state == S_IDLE || w_last);
`endif
  assign w_acc    = i_valid && o_ready;
  assign o_sdata  = r_sdata;
  assign o_svalid = r_svalid;
  assign o_sfirst = r_sfirst;
  assign o_busy   = r_state != S_IDLE;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shreg  <= '0;
      r_sdata  <= 1'b0;
      r_svalid <= 1'b0;
      r_sfirst <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else if (w_acc) begin
      // First bit goes straight to the output register; the shifter holds the rest
      r_state  <= S_SHIFT;
      r_cnt    <= '0;
      r_shreg  <= w_word << 1;
      r_sdata  <= w_word[WIDTH-1];
      r_svalid <= 1'b1;
      r_sfirst <= 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
      r_par    <= ^i_data;
`endif
    end else if (r_state == S_SHIFT && !w_last) begin
      r_cnt    <= r_cnt + 1'b1;
      r_shreg  <= r_shreg << 1;
      r_sdata  <= r_shreg[WIDTH-1];
      r_sfirst <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
    end else if (w_last) begin
      r_state  <= S_PAR;
      r_sdata  <= r_par;
      r_sfirst <= 1'b0;
`endif
    end else begin
      r_state  <= S_IDLE;
      r_sdata  <= 1'b0;
      r_svalid <= 1'b0;
      r_sfirst <= 1'b0;
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: checks MSB-first and LSB-first serializers against a bit-stream queue model
module tb_piso_serializer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [7:0] dat = 8'h00;
  logic rdy_m, sd_m, sv_m, sf_m, bz_m;
  logic rdy_l, sd_l, sv_l, sf_l, bz_l;
  int errs = 0;
  int checks = 0;
  logic [1:0] qm[$];
  logic [1:0] ql[$];
  logic [1:0] cm = 2'b00;
  logic [1:0] cl = 2'b00;
  logic       vcur = 1'b0;
  logic       acc = 1'b0;
  logic [7:0] sink = 8'h00;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .i_clk(clk), .i_rst(rst), .i_data(dat), .i_valid(vld), .o_ready(rdy_m),
    .o_sdata(sd_m), .o_svalid(sv_m), .o_sfirst(sf_m), .o_busy(bz_m));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .i_clk(clk), .i_rst(rst), .i_data(dat), .i_valid(vld), .o_ready(rdy_l),
    .o_sdata(sd_l), .o_svalid(sv_l), .o_sfirst(sf_l), .o_busy(bz_l));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A word becomes its list of transmitted bits; the first is tagged
  task automatic push(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      qm.push_back({i == 0, d[7-i]});
      ql.push_back({i == 0, d[i]});
    end
`ifdef PISO_SERIALIZER_PARITY_EN
    qm.push_back({1'b0, ^d});
    ql.push_back({1'b0, ^d});
`endif
  endtask

  // One clock: ready is expected only when no bits remain queued behind the current one
  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    vld = v;
    dat = d;
    rst = r;
    #1;
    chk("ready_m", {7'd0, rdy_m}, {7'd0, !r && qm.size() == 0});
    chk("ready_l", {7'd0, rdy_l}, {7'd0, !r && ql.size() == 0});
    acc = v && !r && qm.size() == 0;
    @(posedge clk);
    if (r) begin
      qm.delete();
      ql.delete();
      vcur = 1'b0;
    end else begin
      if (acc) push(d);
      vcur = qm.size() > 0;
      if (vcur) begin
        cm = qm.pop_front();
        cl = ql.pop_front();
      end
    end
    @(negedge clk);
    chk("svalid_m", {7'd0, sv_m}, {7'd0, vcur});
    chk("sdata_m",  {7'd0, sd_m}, {7'd0, vcur & cm[0]});
    chk("sfirst_m", {7'd0, sf_m}, {7'd0, vcur & cm[1]});
    chk("busy_m",   {7'd0, bz_m}, {7'd0, vcur});
    chk("svalid_l", {7'd0, sv_l}, {7'd0, vcur});
    chk("sdata_l",  {7'd0, sd_l}, {7'd0, vcur & cl[0]});
    chk("sfirst_l", {7'd0, sf_l}, {7'd0, vcur & cl[1]});
    chk("busy_l",   {7'd0, bz_l}, {7'd0, vcur});
    if (sv_m) sink = {sink[6:0], sd_m};
  endtask

  // Hold the word with i_valid high until it is accepted
  task automatic sendw(input logic [7:0] d);
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, d, 1'b0);
      if (acc) return;
    end
    chk("accept_timeout", 8'h00, 8'h01);
  endtask

  initial begin
    @(negedge clk);
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    sink = 8'h00;
    sendw(8'hA5);
    repeat (7) cyc(1'b0, 8'h00, 1'b0);
    chk("sink_a5", sink, 8'hA5);
    repeat (4) cyc(1'b0, 8'h00, 1'b0);
    sendw(8'hFF);
    sendw(8'h00);
    repeat (12) cyc(1'b0, 8'h00, 1'b0);
    sendw(8'h01);
    repeat (12) cyc(1'b0, 8'h00, 1'b0);
    sendw(8'h3C);
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    repeat (10) cyc(1'b0, 8'h00, 1'b0);
    sendw(8'h07);
    sendw(8'h03);
    repeat (12) cyc(1'b0, 8'h00, 1'b0);
    for (int n = 0; n < 150; n++) begin
      sendw(8'($urandom));
      repeat ($urandom_range(0, 2)) cyc(1'b0, 8'($urandom), 1'b0);
    end
    repeat (12) cyc(1'b0, 8'h00, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
